// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the CPU pipeline stage registers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    function automatic pipe_state_e state_of(input logic out_valid, input logic skid_valid);
        return skid_valid ? TWO : (out_valid ? ONE : EMPTY);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter, cleared only by synchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage with one-entry skid buffer, flush-to-bubble
// and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              nxt_out_valid, nxt_skid_valid;
    logic [DATA_W-1:0] nxt_out_data, nxt_skid_data;
    logic              accept, drain;
    pipe_state_e       state;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;
    assign state  = state_of(out_valid, skid_valid);

    always_comb begin
        nxt_out_valid  = out_valid;
        nxt_out_data   = out_data;
        nxt_skid_valid = skid_valid;
        nxt_skid_data  = skid_data;
        if (flush) begin
            nxt_out_valid  = 1'b0;
            nxt_out_data   = BUBBLE;
            nxt_skid_valid = 1'b0;
            nxt_skid_data  = BUBBLE;
        end else if (state == TWO) begin
            if (drain) begin
                nxt_out_data   = skid_data;
                nxt_skid_valid = 1'b0;
                nxt_skid_data  = BUBBLE;
            end
        end else if (state == ONE) begin
            if (accept && drain) begin
                nxt_out_data = in_data;
            end else if (accept) begin
                nxt_skid_valid = 1'b1;
                nxt_skid_data  = in_data;
            end else if (drain) begin
                nxt_out_valid = 1'b0;
                nxt_out_data  = BUBBLE;
            end
        end else if (accept) begin
            nxt_out_valid = 1'b1;
            nxt_out_data  = in_data;
        end
    end

    // in_ready is taken from the next skid state so it never depends on out_ready combinationally
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= nxt_out_valid;
            out_data   <= nxt_out_data;
            skid_valid <= nxt_skid_valid;
            skid_data  <= nxt_skid_data;
            in_ready   <= !nxt_skid_valid;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

    a_skid_needs_main: assert property (@(posedge clock) disable iff (!reset) skid_valid |-> out_valid);
    a_bubble_when_idle: assert property (@(posedge clock) disable iff (!reset) !out_valid |-> out_data == BUBBLE);
    a_ready_tracks_skid: assert property (@(posedge clock) disable iff (!reset) in_ready == !skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and queue-checked random tests of pipe_stage_reg (DATA_W=96, CNT_W=4).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 96;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] stall_cnt;
    int            passed = 0, fails = 0, total = 0;
    logic [DW-1:0] q[$];

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE('0), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic acc, drn;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_stall", DW'(stall_cnt), 0);
        reset = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
            chk("stream_valid", DW'(out_valid), 1);
            chk("stream_data", out_data, DW'(i));
            chk("stream_ready", DW'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", DW'(out_valid), 0);
        chk("stream_end_data", out_data, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hA;
        step();
        chk("bp_a_data", out_data, 'hA);
        chk("bp_a_ready", DW'(in_ready), 1);
        in_data = 'hB;
        step();
        chk("bp_two_ready", DW'(in_ready), 0);
        in_data = 'hC;
        step(); step();
        chk("bp_hold_data", out_data, 'hA);
        chk("bp_hold_ready", DW'(in_ready), 0);
        chk("bp_stall", DW'(stall_cnt), 3);
        out_ready = 1'b1;
        step();
        chk("bp_b_data", out_data, 'hB);
        chk("bp_b_ready", DW'(in_ready), 1);
        step();
        chk("bp_c_data", out_data, 'hC);
        in_valid = 1'b0;
        step();
        chk("bp_empty", DW'(out_valid), 0);
        chk("bp_stall_final", DW'(stall_cnt), 3);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hA;
        step();
        in_data = 'hB;
        step();
        chk("fl_two_ready", DW'(in_ready), 0);
        in_data = 'hC; flush = 1'b1;
        step();
        chk("fl_valid", DW'(out_valid), 0);
        chk("fl_data", out_data, 0);
        chk("fl_ready", DW'(in_ready), 1);
        chk("fl_stall", DW'(stall_cnt), 5);
        flush = 1'b0; in_data = 'hD; out_ready = 1'b1;
        step();
        chk("fl_d_valid", DW'(out_valid), 1);
        chk("fl_d_data", out_data, 'hD);
        in_valid = 1'b0;
        step();
        chk("fl_d_gone", DW'(out_valid), 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h7;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat_15", DW'(stall_cnt), 15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_after_flush", DW'(stall_cnt), 15);
        chk("sat_flush_valid", DW'(out_valid), 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("sat_reset", DW'(stall_cnt), 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h1;
        step();
        in_data = 'h2;
        step();
        in_data = 'h3; flush = 1'b1; reset = 1'b0;
        step();
        chk("mid_valid", DW'(out_valid), 0);
        chk("mid_data", out_data, 0);
        chk("mid_ready", DW'(in_ready), 1);
        chk("mid_stall", DW'(stall_cnt), 0);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("mid_no_emerge", DW'(out_valid), 0);
        end

        for (int c = 0; c < 300; c++) begin
            chk("rnd_valid", DW'(out_valid), DW'(q.size() != 0));
            chk("rnd_ready", DW'(in_ready), DW'(q.size() < 2));
            if (q.size() != 0) chk("rnd_data", out_data, q[0]);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = {$urandom, $urandom, $urandom};
            acc = in_valid && (q.size() < 2);
            drn = (q.size() != 0) && out_ready;
            step();
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(in_data);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (q.size() != 0) chk("drain_data", out_data, q[0]);
            if (q.size() != 0) void'(q.pop_front());
            step();
        end
        chk("drain_empty", DW'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register replacing the fixed 64-bit IF/ID latch. It carries an arbitrary-width payload (default PC plus instruction) between two CPU pipeline stages with a valid/ready handshake and a one-entry skid buffer. It supports flush-to-bubble and a saturating stall-cycle counter for the hazard unit and debug. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 64: payload width in bits (IF/ID uses PC in [63:32], instruction in [31:0]).
- BUBBLE, 0: DATA_W-bit value driven on out_data when out_valid is 0; 0 encodes the MIPS NOP.
- CNT_W, 16: stall counter width in bits.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  stage can accept a payload; registered.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  discard all held and incoming payloads (branch or jump taken).
- out_valid  out  1  downstream payload valid; registered.
- out_ready  in  1  downstream accepts; hazard-unit stall drives this low.
- out_data  out  DATA_W  registered payload; equals BUBBLE whenever out_valid is 0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Storage is a main register (out_valid, out_data) and a skid register (skid_valid, skid_data).
- State is derived from the valid bits: EMPTY (out_valid=0), ONE (out_valid=1, skid_valid=0), TWO (both valid). skid_valid=1 with out_valid=0 is illegal and must never occur.
- in_ready = !skid_valid, registered.
- Accept happens when in_valid && in_ready. Drain happens when out_valid && out_ready.
- Transitions (no flush):
  - EMPTY + accept -> ONE, out_data<=in_data.
  - ONE + accept + drain -> ONE, out_data<=in_data.
  - ONE + accept, no drain -> TWO, skid_data<=in_data.
  - ONE + drain, no accept -> EMPTY, out_data<=BUBBLE.
  - TWO + drain -> ONE, out_data<=skid_data, skid cleared. No accept is possible in TWO because in_ready=0.
  - Any state with no event: hold.
- Flush has priority over all handshake activity:
  - next state is EMPTY;
  - out_data<=BUBBLE, skid_data<=BUBBLE;
  - a same-cycle in_valid is dropped, even though in_ready may read 1;
  - a same-cycle drain still counts as transferred downstream.
- stall_cnt increments by 1 in every cycle with out_valid && !out_ready, including a cycle in which flush is also asserted.
  - Holds at all ones (2^CNT_W-1) once saturated.
  - Cleared only by reset. Flush does not clear it.
- Payload ordering is strictly FIFO. No payload is duplicated or lost except by flush.

## Timing
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N. This is 1 cycle through an empty stage, or 1 cycle after the blocking payload drains.
- Throughput: 1 payload per cycle while out_ready=1.
- in_ready falls the cycle after the stage reaches TWO and rises the cycle after TWO drains. No combinational path exists from out_ready to in_ready.
- Reset (reset=0 at an edge) forces, after that edge:
  - out_valid=0, out_data=BUBBLE;
  - skid_valid=0, skid_data=BUBBLE;
  - in_ready=1, stall_cnt=0.
- Reset overrides flush and handshakes. Reset asserted mid-transfer discards both entries.
- Simultaneous flush and reset: reset result.

## Structure
- Shared package pipe_pkg:
  - NOP_INSTR = 32'h0000_0000;
  - typedef for the IF/ID payload struct (pc, instr);
  - enum for the derived state (EMPTY, ONE, TWO), used by assertions and the bench.
- One sub-module is natural: sat_counter (parameter W; inputs clock, reset, inc; output count). Reuse it for other performance counters.
- Assertions in the module:
  - no TWO state without ONE (skid_valid implies out_valid);
  - out_data==BUBBLE whenever !out_valid;
  - in_ready==!skid_valid.

## Test plan
- Reset, then stream: hold reset=0 for 2 cycles, then send 0x1..0x5 with out_ready=1 -> outputs 0x1..0x5 on consecutive cycles, each 1 cycle after input; in_ready stays 1.
- Backpressure: send 0xA, 0xB, 0xC with out_ready=0 from cycle 1 -> 0xA held, 0xB in skid, in_ready=0, 0xC held upstream. After out_ready=1: 0xA, 0xB, 0xC emitted in order; stall_cnt equals the number of blocked cycles.
- Flush in TWO state: flush with 0xA and 0xB held and in_valid carrying 0xC -> next cycle out_valid=0, out_data=0, in_ready=1. 0xC is dropped; a subsequent 0xD emerges next.
- Saturation: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15; a flush leaves it at 15; reset returns it to 0.
- Reset mid-operation: reset=0 while in TWO with flush=1 -> after the edge all outputs are at reset values, and no payload emerges afterwards.
- Randomised valid/ready with DATA_W=96, compared against a reference queue -> no loss, duplication, or reordering; all assertions hold.
